// File: rtl/shift_pkg.sv
// shift_pkg: operation and FSM state encodings for the universal shift register
package shift_pkg;
  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_ASR  = 3'd6,
    M_RSVD = 3'd7
  } mode_t;
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: next register value for one operation, shared by single-step and burst paths
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             si_l,
  input  logic             si_r,
  output logic [WIDTH-1:0] q_next
);
  always_comb begin
    case (mode)
      M_LOAD:  q_next = d;
      M_SHL:   q_next = {q[WIDTH-2:0], si_l};
      M_SHR:   q_next = {si_r, q[WIDTH-1:1]};
      M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      M_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with single-step ops and counted burst mode
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH*2+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si_l,
  input  logic             si_r,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);
  state_t           state, state_n;
  mode_t            lmode, lmode_n, mode_in, step_mode;
  logic [CNT_W-1:0] rem, rem_n;
  logic [WIDTH-1:0] q_n, step_q;
  logic             done_n, is_shift;
  assign mode_in   = mode_t'(mode);
  assign is_shift  = mode_in inside {M_SHL, M_SHR, M_ROL, M_ROR, M_ASR};
  assign step_mode = (state == BURST) ? lmode : mode_in;
  assign so_l      = q[WIDTH-1];
  assign so_r      = q[0];
  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode  (step_mode),
    .q     (q),
    .d     (d),
    .si_l  (si_l),
    .si_r  (si_r),
    .q_next(step_q)
  );
  always_comb begin
    state_n = state;
    lmode_n = lmode;
    rem_n   = rem;
    q_n     = q;
    done_n  = 1'b0;
    if (state == BURST) begin
      q_n     = step_q;
      rem_n   = rem - CNT_W'(1);
      state_n = (rem == CNT_W'(1)) ? IDLE : BURST;
      done_n  = (rem == CNT_W'(1));
    end else if (start && is_shift) begin
      done_n = (count <= CNT_W'(1));
      if (count != '0) begin
        q_n     = step_q;
        lmode_n = mode_in;
        rem_n   = count - CNT_W'(1);
        state_n = (count == CNT_W'(1)) ? IDLE : BURST;
      end
    end else if (start || en) begin
      q_n = step_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lmode <= M_HOLD;
      rem   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      lmode <= lmode_n;
      rem   <= rem_n;
      q     <= q_n;
      busy  <= (state_n == BURST);
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8)
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH*2+1);
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, RSVD = 3'd7;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       mode = HOLD;
  logic [WIDTH-1:0] d = '0;
  logic             si_l = 1'b0, si_r = 1'b0, en = 1'b0, start = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic [WIDTH-1:0] q;
  logic             so_l, so_r, busy, done;
  int errors = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .si_l(si_l), .si_r(si_r),
    .en(en), .start(start), .count(count), .q(q), .so_l(so_l), .so_r(so_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    mode = LOAD; d = v; en = 1'b1;
    step();
    en = 1'b0; mode = HOLD;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if ({so_l, so_r, busy, done} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {so_l, so_r, busy, done}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    load(8'hA5);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q: got %h want a5", q); end
    checks++; if ({so_l, so_r, busy, done} !== 4'b1100) begin errors++; $display("FAIL load_flags: got %b want 1100", {so_l, so_r, busy, done}); end
  endtask

  task automatic test_rol_burst();
    load(8'h81);
    mode = ROL; count = 3; start = 1'b1;
    step();
    start = 1'b0; mode = HOLD;
    checks++; if ({q, busy, done} !== {8'h03, 2'b10}) begin errors++; $display("FAIL rol_e1: got %h/%b%b want 03/10", q, busy, done); end
    step();
    checks++; if ({q, busy, done} !== {8'h06, 2'b10}) begin errors++; $display("FAIL rol_e2: got %h/%b%b want 06/10", q, busy, done); end
    step();
    checks++; if ({q, busy, done} !== {8'h0C, 2'b01}) begin errors++; $display("FAIL rol_e3: got %h/%b%b want 0c/01", q, busy, done); end
    step();
    checks++; if ({q, busy, done} !== {8'h0C, 2'b00}) begin errors++; $display("FAIL rol_after: got %h/%b%b want 0c/00", q, busy, done); end
  endtask

  task automatic test_asr_shr();
    load(8'h90);
    mode = ASR; count = 2; start = 1'b1;
    step();
    start = 1'b0; mode = HOLD;
    step();
    checks++; if ({q, done} !== {8'hE4, 1'b1}) begin errors++; $display("FAIL asr_burst: got %h/%b want e4/1", q, done); end
    mode = SHR; si_r = 1'b0; en = 1'b1;
    step();
    en = 1'b0; mode = HOLD;
    checks++; if ({q, done} !== {8'h72, 1'b0}) begin errors++; $display("FAIL shr_step: got %h/%b want 72/0", q, done); end
  endtask

  task automatic test_saturate();
    int busy_cnt = 0;
    load(8'h00);
    mode = SHL; si_l = 1'b1; count = 10; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      start = 1'b0;
      if (k < 10) busy_cnt += int'(busy);
      if (k == 3) begin
        checks++; if (q !== 8'h07) begin errors++; $display("FAIL sat_e3: got %h want 07", q); end
      end
      d = 8'h55;
      en = (k < 9) ? k[0] : 1'b0;
      mode = (k < 9) ? (k[0] ? LOAD : ROR) : HOLD;
    end
    checks++; if ({q, busy, done} !== {8'hFF, 2'b01}) begin errors++; $display("FAIL sat_final: got %h/%b%b want ff/01", q, busy, done); end
    checks++; if (busy_cnt !== 9) begin errors++; $display("FAIL sat_busy_cycles: got %0d want 9", busy_cnt); end
    si_l = 1'b0;
  endtask

  task automatic test_count_zero();
    int busy_seen = 0;
    load(8'h3C);
    mode = SHL; count = 0; start = 1'b1;
    step();
    start = 1'b0; mode = HOLD;
    busy_seen += int'(busy);
    checks++; if ({q, done} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL cnt0_pulse: got %h/%b want 3c/1", q, done); end
    step();
    busy_seen += int'(busy);
    checks++; if ({q, done} !== {8'h3C, 1'b0}) begin errors++; $display("FAIL cnt0_after: got %h/%b want 3c/0", q, done); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL cnt0_busy: got %0d want 0", busy_seen); end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    mode = ROL; count = 1; start = 1'b1;
    step();
    checks++; if ({q, busy, done} !== {8'h02, 2'b01}) begin errors++; $display("FAIL b2b_n1: got %h/%b%b want 02/01", q, busy, done); end
    mode = ROR; count = 2;
    step();
    start = 1'b0; mode = HOLD;
    checks++; if ({q, busy, done} !== {8'h01, 2'b10}) begin errors++; $display("FAIL b2b_e1: got %h/%b%b want 01/10", q, busy, done); end
    step();
    checks++; if ({q, busy, done} !== {8'h80, 2'b01}) begin errors++; $display("FAIL b2b_e2: got %h/%b%b want 80/01", q, busy, done); end
  endtask

  task automatic test_reserved();
    load(8'h5A);
    mode = RSVD; en = 1'b1;
    step();
    en = 1'b0;
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL rsvd_en: got %h want 5a", q); end
    start = 1'b1; count = 3;
    step();
    start = 1'b0; mode = HOLD;
    checks++; if ({q, busy, done} !== {8'h5A, 2'b00}) begin errors++; $display("FAIL rsvd_start: got %h/%b%b want 5a/00", q, busy, done); end
    mode = LOAD; d = 8'hC3; start = 1'b1; count = 4;
    step();
    start = 1'b0; mode = HOLD;
    checks++; if ({q, busy, done} !== {8'hC3, 2'b00}) begin errors++; $display("FAIL load_start: got %h/%b%b want c3/00", q, busy, done); end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    load(8'hFF);
    mode = SHR; si_r = 1'b0; count = 5; start = 1'b1;
    step();
    start = 1'b0; mode = HOLD;
    step();
    checks++; if ({q, busy} !== {8'h3F, 1'b1}) begin errors++; $display("FAIL mid_e2: got %h/%b want 3f/1", q, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({q, busy, done} !== {8'h00, 2'b00}) begin errors++; $display("FAIL mid_reset: got %h/%b%b want 00/00", q, busy, done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      done_seen += int'(done) + int'(busy);
    end
    checks++; if ({q, done_seen} !== {8'h00, 32'd0}) begin errors++; $display("FAIL mid_after: got %h/%0d want 00/0", q, done_seen); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rol_burst();
    test_asr_shr();
    test_saturate();
    test_count_zero();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the next generation of the team's 4-bit parallel-in shift register, generalised to WIDTH bits. It supports hold, parallel load, logical shift left/right with serial fill, rotate left/right and arithmetic shift right. It adds a counted burst mode: one START runs N back-to-back shifts under an internal counter and reports BUSY/DONE. It serves as the serialiser/deserialiser and bit-manipulation stage for neighbouring datapath blocks.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH*2+1), width of the burst count (derived; do not override)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- MODE  in  3  operation select (encoding in package)
- D  in  WIDTH  parallel load data
- SI_L  in  1  serial fill into bit 0 on SHL
- SI_R  in  1  serial fill into bit WIDTH-1 on SHR
- EN  in  1  single-step strobe: perform MODE once
- START  in  1  begin burst of COUNT operations of MODE
- COUNT  in  CNT_W  burst length, sampled with START
- Q  out  WIDTH  register contents
- SO_L  out  1  Q[WIDTH-1] (combinational from Q)
- SO_R  out  1  Q[0] (combinational from Q)
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse on burst completion

## Operation
- MODE encodings: HOLD=0, LOAD=1, SHL=2, SHR=3, ROL=4, ROR=5, ASR=6; 7 reserved, behaves as HOLD.
- SHL: Q <= {Q[WIDTH-2:0], SI_L}. SHR: Q <= {SI_R, Q[WIDTH-1:1]}. ROL/ROR: rotate by one. ASR: MSB replicated. LOAD: Q <= D.
- States: IDLE, BURST.
- IDLE, START=1, COUNT≥1, MODE ∈ {SHL,SHR,ROL,ROR,ASR}: perform the first op on this edge, latch MODE, remaining <= COUNT-1. If remaining ≠ 0, go to BURST; otherwise stay in IDLE and pulse DONE.
- IDLE, START=1, COUNT=0: Q unchanged, DONE pulsed, stay in IDLE.
- IDLE, START=1, MODE ∈ {HOLD, LOAD, reserved}: treated as EN (single op), no DONE.
- IDLE, START=0, EN=1: one op per MODE. START has priority over EN.
- BURST: each edge performs the latched op, decrementing remaining. At remaining=1, the final op executes, the state returns to IDLE and DONE is set. While in BURST, MODE, EN, START, COUNT and D are ignored. SI_L/SI_R are sampled live every edge.
- COUNT > WIDTH is legal: shifts saturate to all-fill or all-sign, and rotates wrap modulo WIDTH.

## Timing
- Reset (RST_N low, asynchronous): Q=0, SO_L=0, SO_R=0, BUSY=0, DONE=0, state IDLE, remaining=0. Effective immediately.
- Reset mid-burst aborts the burst: no DONE, Q=0.
- Single op latency: 1 edge.
- Burst of N≥1: the op runs on the START edge and on the following N-1 edges. Final Q is visible after the N-th edge. DONE is high for exactly the cycle following the N-th edge.
- BUSY is registered. It is high after each burst edge where remaining > 0, so it is asserted for N-1 cycles (0 cycles for N=1).
- A new START is accepted in the same cycle DONE is high (back-to-back bursts).

## Structure
- shift_pkg contains: mode_t enum (7 modes + reserved), and state_t enum (IDLE, BURST).
- Sub-module shift_step: combinational function of (mode, Q, D, SI_L, SI_R) returning the next Q. It is shared by the single-step and burst paths.
- The top level holds the FSM, the remaining counter, the latched mode and the Q register.

## Test plan
- WIDTH=8, reset, then MODE=LOAD, D=0xA5, EN=1 for one edge -> Q=0xA5, SO_L=1, SO_R=1, BUSY=0, DONE=0.
- Q=0x81, MODE=ROL, START, COUNT=3 -> Q=0x03, 0x06, 0x0C on successive edges; BUSY high 2 cycles; DONE high one cycle after the 3rd edge.
- Q=0x90, MODE=ASR, START, COUNT=2 -> Q=0xE4. Then MODE=SHR, SI_R=0, EN -> Q=0x72.
- Q=0x00, MODE=SHL, SI_L=1, START, COUNT=10 -> Q=0xFF after 10 edges; BUSY high 9 cycles. EN and MODE toggled during the burst have no effect.
- START with COUNT=0 -> Q unchanged, DONE pulse next cycle, BUSY never high.
- START with COUNT=5, then RST_N low after the 2nd edge -> Q=0 and BUSY=0 immediately; no DONE after release.
